// File: rtl/cpu_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cpu_lsu                                                         |
// | Purpose  : Load/store unit between the execute stage and a Wishbone-style  |
// |            data bus. Decodes funct3 size/sign, aligns lanes and store data,|
// |            runs the stall/ack handshake with timeout, extends load data.   |
// | Ports    : i_clk/i_reset      clock, async active-high reset              |
// |            i_req/i_we/i_funct3/i_addr/i_wdata   request from core          |
// |            o_busy/o_done/o_err/o_err_code/o_rdata  status and load result  |
// |            o_wb_stb/o_wb_we/o_wb_addr/o_wb_sel/o_wb_data  bus master side  |
// |            i_wb_stall/i_wb_ack/i_wb_data          bus slave response       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cpu_lsu #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_req,
   input  logic                 i_we,
   input  logic [2:0]           i_funct3,
   input  logic [ADDR_W-1:0]    i_addr,
   input  logic [DATA_W-1:0]    i_wdata,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err,
   output logic [1:0]           o_err_code,
   output logic [DATA_W-1:0]    o_rdata,
   output logic                 o_wb_stb,
   output logic                 o_wb_we,
   output logic [ADDR_W-1:0]    o_wb_addr,
   output logic [DATA_W/8-1:0]  o_wb_sel,
   output logic [DATA_W-1:0]    o_wb_data,
   input  logic                 i_wb_stall,
   input  logic                 i_wb_ack,
   input  logic [DATA_W-1:0]    i_wb_data
);

   localparam int c_SEL_W = DATA_W / 8;
   localparam int c_OFF_W = $clog2(c_SEL_W);
   // Counter only needs to reach TIMEOUT-1: the last allowed cycle.
   localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0] c_TMO_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_OFF_W-1:0]   r_off;
   logic [1:0]           r_size;
   logic                 r_uns;

   // ---------------- request decode (from live inputs in S_IDLE) ----------
   logic [1:0]           w_size;
   logic [c_OFF_W-1:0]   w_off;
   logic [2:0]           w_amask;
   logic [c_SEL_W-1:0]   w_sel_base;
   logic [c_SEL_W-1:0]   w_sel;
   logic [DATA_W-1:0]    w_wdata;
   logic [ADDR_W-1:0]    w_waddr;
   logic                 w_illegal;
   logic                 w_misal;

   assign w_size    = i_funct3[1:0];
   assign w_off     = i_addr[c_OFF_W-1:0];
   assign w_illegal = (i_we & i_funct3[2]) | ((DATA_W == 32) && (w_size == 2'd3));

   always_comb begin
      w_amask    = 3'b000;
      w_sel_base = '0;
      case (w_size)
         2'd0: begin w_amask = 3'b000; w_sel_base = c_SEL_W'(8'h01); end
         2'd1: begin w_amask = 3'b001; w_sel_base = c_SEL_W'(8'h03); end
         2'd2: begin w_amask = 3'b011; w_sel_base = c_SEL_W'(8'h0F); end
         default: begin w_amask = 3'b111; w_sel_base = c_SEL_W'(8'hFF); end
      endcase
   end

   assign w_misal = |(i_addr[2:0] & w_amask);
   assign w_sel   = w_sel_base << w_off;
   assign w_wdata = i_wdata << {w_off, 3'b000};
   assign w_waddr = {i_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};

   // ---------------- load extraction ---------------------------------------
   // Shift the addressed field down, push it to the MSB end, then shift it
   // back logically (zero-extend) or arithmetically (sign-extend).
   logic [DATA_W-1:0]    w_rsh;
   logic [DATA_W-1:0]    w_left;
   logic [DATA_W-1:0]    w_ext;
   logic [6:0]           w_pad;

   assign w_rsh  = i_wb_data >> {r_off, 3'b000};
   assign w_pad  = 7'(DATA_W) - (7'd8 << r_size);
   assign w_left = w_rsh << w_pad;
   assign w_ext  = r_uns ? (w_left >> w_pad) : DATA_W'($signed(w_left) >>> w_pad);

   logic w_tmo;
   assign w_tmo = (TIMEOUT != 0) && (r_cnt == c_TMO_LAST);

   // ---------------- control FSM with registered outputs -------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_off      <= '0;
         r_size     <= '0;
         r_uns      <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
         o_err_code <= 2'd0;
         o_rdata    <= '0;
         o_wb_stb   <= 1'b0;
         o_wb_we    <= 1'b0;
         o_wb_addr  <= '0;
         o_wb_sel   <= '0;
         o_wb_data  <= '0;
      end else begin
         o_done <= 1'b0;
         o_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  o_busy <= 1'b1;
                  r_off  <= w_off;
                  r_size <= w_size;
                  r_uns  <= i_funct3[2];
                  if (w_illegal) begin
                     r_state    <= S_DONE;
                     o_done     <= 1'b1;
                     o_err      <= 1'b1;
                     o_err_code <= 2'd2;
                  end else if (w_misal) begin
                     r_state    <= S_DONE;
                     o_done     <= 1'b1;
                     o_err      <= 1'b1;
                     o_err_code <= 2'd1;
                  end else begin
                     r_state   <= S_REQ;
                     r_cnt     <= '0;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= i_we;
                     o_wb_addr <= w_waddr;
                     o_wb_sel  <= w_sel;
                     o_wb_data <= w_wdata;
                  end
               end
            end
            S_REQ: begin
               r_cnt <= r_cnt + c_CNT_W'(1);
               if (!i_wb_stall) begin
                  o_wb_stb <= 1'b0;
                  if (i_wb_ack) begin
                     r_state    <= S_DONE;
                     o_done     <= 1'b1;
                     o_err_code <= 2'd0;
                     if (!o_wb_we) o_rdata <= w_ext;
                  end else if (w_tmo) begin
                     r_state    <= S_DONE;
                     o_done     <= 1'b1;
                     o_err      <= 1'b1;
                     o_err_code <= 2'd3;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end else if (w_tmo) begin
                  o_wb_stb   <= 1'b0;
                  r_state    <= S_DONE;
                  o_done     <= 1'b1;
                  o_err      <= 1'b1;
                  o_err_code <= 2'd3;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt + c_CNT_W'(1);
               if (i_wb_ack) begin
                  r_state    <= S_DONE;
                  o_done     <= 1'b1;
                  o_err_code <= 2'd0;
                  if (!o_wb_we) o_rdata <= w_ext;
               end else if (w_tmo) begin
                  r_state    <= S_DONE;
                  o_done     <= 1'b1;
                  o_err      <= 1'b1;
                  o_err_code <= 2'd3;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
